// File: rtl/hash_addr_engine.sv
// Two-stage weight-address generator: (layer, in/out activation index) -> weight SRAM address
// via a per-layer seeded pseudo-hash or direct index concatenation, with valid/ready and flush.
module hash_addr_engine #(
    parameter int PE_IDX   = 0,
    parameter int LAYER_W  = 4,
    parameter int IDX_W    = 10,
    parameter int ACT_NO_W = 8,
    parameter int DATA_W   = 16,
    parameter int WADDR_W  = 12
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                cfg_we,
    input  logic [LAYER_W-1:0]  cfg_layer,
    input  logic [15:0]         cfg_seed,
    input  logic                cfg_hash,
    input  logic                flush,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [LAYER_W-1:0]  layer_idx,
    input  logic [IDX_W-1:0]    in_act_idx,
    input  logic [IDX_W-1:0]    out_act_idx,
    input  logic [ACT_NO_W-1:0] out_act_addr,
    input  logic [DATA_W-1:0]   in_act_value,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W-1:0]   in_act_value_mem,
    output logic [ACT_NO_W-1:0] out_act_addr_mem,
    output logic                w_sign_mem,
    output logic                w_mem_cen,
    output logic                w_mem_wen,
    output logic [WADDR_W-1:0]  w_mem_addr
);
    localparam int DEPTH = 2**LAYER_W;

    logic [15:0]      seed_tab [DEPTH];
    logic [DEPTH-1:0] mode_tab;

    logic                s1_valid;
    logic [31:0]         s1_x;
    logic                s1_hash;
    logic [IDX_W-1:0]    s1_in_idx;
    logic [IDX_W-1:0]    s1_out_idx;
    logic [ACT_NO_W-1:0] s1_act_addr;
    logic [DATA_W-1:0]   s1_act_value;

    logic                s2_valid;
    logic [WADDR_W-1:0]  s2_addr;
    logic                s2_sign;
    logic [ACT_NO_W-1:0] s2_act_addr;
    logic [DATA_W-1:0]   s2_act_value;

    logic s1_en, s2_en;
    logic [31:0] x_next, h;
    logic [2*IDX_W+WADDR_W-1:0] direct_cat;
    logic [WADDR_W-1:0] addr_next;
    logic sign_next;
    logic unused_bits;

    always_comb begin
        s2_en = !s2_valid || out_ready;
        s1_en = !s1_valid || s2_en;
        // Table is read combinationally, so a same-cycle config write is not yet visible.
        x_next = (32'(in_act_idx) * 32'h9E3779B1)
               ^ (32'(out_act_idx) * 32'h85EBCA6B)
               ^ {seed_tab[layer_idx], seed_tab[layer_idx]}
               ^ 32'(PE_IDX);
        h = s1_x ^ (s1_x >> 16);
        direct_cat = {{WADDR_W{1'b0}}, s1_out_idx, s1_in_idx};
        if (s1_hash) begin
            addr_next = h[WADDR_W-1:0];
            sign_next = h[31];
        end else begin
            addr_next = direct_cat[WADDR_W-1:0];
            sign_next = 1'b0;
        end
    end

    assign unused_bits = ^{h, direct_cat};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) seed_tab[i] <= '0;
            mode_tab     <= '0;
            s1_valid     <= 1'b0;
            s1_x         <= '0;
            s1_hash      <= 1'b0;
            s1_in_idx    <= '0;
            s1_out_idx   <= '0;
            s1_act_addr  <= '0;
            s1_act_value <= '0;
            s2_valid     <= 1'b0;
            s2_addr      <= '0;
            s2_sign      <= 1'b0;
            s2_act_addr  <= '0;
            s2_act_value <= '0;
        end else begin
            if (cfg_we) begin
                seed_tab[cfg_layer] <= cfg_seed;
                mode_tab[cfg_layer] <= cfg_hash;
            end
            if (flush) begin
                s1_valid     <= 1'b0;
                s1_x         <= '0;
                s1_hash      <= 1'b0;
                s1_in_idx    <= '0;
                s1_out_idx   <= '0;
                s1_act_addr  <= '0;
                s1_act_value <= '0;
                s2_valid     <= 1'b0;
                s2_addr      <= '0;
                s2_sign      <= 1'b0;
                s2_act_addr  <= '0;
                s2_act_value <= '0;
            end else begin
                if (s1_en) begin
                    s1_valid     <= in_valid;
                    s1_x         <= x_next;
                    s1_hash      <= mode_tab[layer_idx];
                    s1_in_idx    <= in_act_idx;
                    s1_out_idx   <= out_act_idx;
                    s1_act_addr  <= out_act_addr;
                    s1_act_value <= in_act_value;
                end
                if (s2_en) begin
                    s2_valid     <= s1_valid;
                    s2_addr      <= addr_next;
                    s2_sign      <= sign_next;
                    s2_act_addr  <= s1_act_addr;
                    s2_act_value <= s1_act_value;
                end
            end
        end
    end

    assign in_ready         = s1_en && !flush;
    assign out_valid        = s2_valid;
    assign in_act_value_mem = s2_act_value;
    assign out_act_addr_mem = s2_act_addr;
    assign w_sign_mem       = s2_sign;
    // One SRAM read per transaction, fired at the downstream handshake.
    assign w_mem_cen        = !(s2_valid && out_ready && !flush);
    assign w_mem_wen        = 1'b1;
    assign w_mem_addr       = s2_valid ? s2_addr : '0;
endmodule

// File: tb/tb_hash_addr_engine.sv
// Directed bench for hash_addr_engine: vector table for address/sign mapping plus
// hand-written sequences for reset, backpressure, same-cycle config and flush.
module tb_hash_addr_engine;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        cfg_we;
    logic [3:0]  cfg_layer;
    logic [15:0] cfg_seed;
    logic        cfg_hash;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  layer_idx;
    logic [9:0]  in_act_idx;
    logic [9:0]  out_act_idx;
    logic [7:0]  out_act_addr;
    logic [15:0] in_act_value;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] in_act_value_mem;
    logic [7:0]  out_act_addr_mem;
    logic        w_sign_mem;
    logic        w_mem_cen;
    logic        w_mem_wen;
    logic [11:0] w_mem_addr;

    int tests = 0;
    int fails = 0;

    hash_addr_engine dut (
        .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
        .cfg_seed(cfg_seed), .cfg_hash(cfg_hash), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .layer_idx(layer_idx),
        .in_act_idx(in_act_idx), .out_act_idx(out_act_idx),
        .out_act_addr(out_act_addr), .in_act_value(in_act_value),
        .out_valid(out_valid), .out_ready(out_ready),
        .in_act_value_mem(in_act_value_mem), .out_act_addr_mem(out_act_addr_mem),
        .w_sign_mem(w_sign_mem), .w_mem_cen(w_mem_cen), .w_mem_wen(w_mem_wen),
        .w_mem_addr(w_mem_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  layer;
        logic [9:0]  in_idx;
        logic [9:0]  out_idx;
        logic [11:0] addr;
        logic        sign;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic do_cfg(input logic [3:0] l, input logic [15:0] s, input logic hm);
        cfg_we = 1'b1; cfg_layer = l; cfg_seed = s; cfg_hash = hm;
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic drive_req(input logic [3:0] l, input logic [9:0] ii, input logic [9:0] oi,
                             input logic [7:0] aa, input logic [15:0] av);
        in_valid = 1'b1; layer_idx = l; in_act_idx = ii; out_act_idx = oi;
        out_act_addr = aa; in_act_value = av;
    endtask

    // Single request through an empty pipeline with out_ready=1; called just after a negedge.
    task automatic run_one(input string name, input logic [3:0] l, input logic [9:0] ii,
                           input logic [9:0] oi, input logic [11:0] ea, input logic es,
                           input logic [7:0] aa);
        drive_req(l, ii, oi, aa, {8'hA5, aa});
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk({name, ".s1_no_valid"}, 32'(out_valid), 32'd0);
        @(negedge clk); #1;
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".addr"}, 32'(w_mem_addr), 32'(ea));
        chk({name, ".sign"}, 32'(w_sign_mem), 32'(es));
        chk({name, ".cen"}, 32'(w_mem_cen), 32'd0);
        chk({name, ".sideband"}, {8'h0, out_act_addr_mem, in_act_value_mem},
            {8'h0, aa, 8'hA5, aa});
        @(negedge clk); #1;
        chk({name, ".drained"}, {30'd0, out_valid, w_mem_cen}, 32'b01);
    endtask

    logic [11:0] bp_exp [4];
    int tx, rx, iters;
    logic acc, hs;

    initial begin
        vecs[0] = '{4'd0, 10'd3,   10'd5,   12'h403, 1'b0};
        vecs[1] = '{4'd1, 10'd1,   10'd0,   12'h786, 1'b1};
        vecs[2] = '{4'd1, 10'd2,   10'd0,   12'hF0C, 1'b0};
        vecs[3] = '{4'd1, 10'd0,   10'd1,   12'hF80, 1'b1};
        vecs[4] = '{4'd1, 10'd1,   10'd1,   12'h806, 1'b0};
        vecs[5] = '{4'd2, 10'd0,   10'd0,   12'h000, 1'b1};
        vecs[6] = '{4'd2, 10'd1,   10'd0,   12'h786, 1'b0};
        vecs[7] = '{4'd3, 10'h3FF, 10'h3FF, 12'hFFF, 1'b0};
        vecs[8] = '{4'd0, 10'h155, 10'd2,   12'h955, 1'b0};

        rst_n = 1'b0; cfg_we = 1'b0; cfg_layer = '0; cfg_seed = '0; cfg_hash = 1'b0;
        flush = 1'b0; out_ready = 1'b1;
        drive_req(4'd0, 10'd3, 10'd5, 8'h11, 16'h2222);

        // Reset held two cycles with a request pending.
        repeat (2) begin
            @(negedge clk); #1;
            chk("reset.outs", {28'd0, out_valid, w_mem_cen, w_mem_wen, |w_mem_addr}, 32'b0110);
        end
        rst_n = 1'b1; in_valid = 1'b0;
        #1 chk("reset.in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);

        do_cfg(4'd1, 16'h0000, 1'b1);
        do_cfg(4'd2, 16'h8000, 1'b1);
        do_cfg(4'd3, 16'h5555, 1'b0);
        do_cfg(4'd4, 16'h0000, 1'b1);

        for (int i = 0; i < 9; i++)
            run_one($sformatf("vec%0d", i), vecs[i].layer, vecs[i].in_idx, vecs[i].out_idx,
                    vecs[i].addr, vecs[i].sign, 8'(i));

        // Backpressure: 4 requests with downstream stalled, then released.
        for (int k = 0; k < 4; k++) bp_exp[k] = 12'(k + 1);
        out_ready = 1'b0; tx = 0;
        for (int c = 0; c < 6; c++) begin
            drive_req(4'd0, 10'(tx + 1), 10'd0, 8'(8'h40 + tx), 16'h0);
            #1 acc = in_ready;
            if (c >= 3) begin
                chk("bp.stall_ready", 32'(in_ready), 32'd0);
                chk("bp.stall_cen", 32'(w_mem_cen), 32'd1);
                chk("bp.stall_hold", {19'd0, out_valid, w_mem_addr}, {19'd0, 1'b1, bp_exp[0]});
            end
            @(negedge clk);
            if (acc) tx++;
        end
        chk("bp.accepted", 32'(tx), 32'd2);
        out_ready = 1'b1; rx = 0; iters = 0;
        while (rx < 4 && iters < 20) begin
            in_valid = (tx < 4);
            in_act_idx = 10'(tx + 1); out_act_addr = 8'(8'h40 + tx);
            #1 acc = in_valid && in_ready;
            hs = out_valid && out_ready;
            if (hs) begin
                chk($sformatf("bp.order%0d", rx), {12'd0, out_act_addr_mem, w_mem_addr},
                    {12'd0, 8'(8'h40 + rx), bp_exp[rx]});
                chk($sformatf("bp.cen%0d", rx), 32'(w_mem_cen), 32'd0);
            end
            @(negedge clk);
            if (acc) tx++;
            if (hs) rx++;
            iters++;
        end
        in_valid = 1'b0;
        chk("bp.one_per_cycle", {16'(rx), 16'(iters)}, {16'd4, 16'd4});
        @(negedge clk);

        // Config written in the same cycle a layer-4 request is accepted.
        drive_req(4'd4, 10'd0, 10'd0, 8'h01, 16'h0);
        cfg_we = 1'b1; cfg_layer = 4'd4; cfg_seed = 16'h9234; cfg_hash = 1'b1;
        @(negedge clk);
        cfg_we = 1'b0;
        drive_req(4'd4, 10'd0, 10'd0, 8'h02, 16'h0);
        @(negedge clk);
        in_valid = 1'b0;
        #1 chk("cfg.old_seed", {23'd0, out_valid, out_act_addr_mem, w_sign_mem},
               {23'd0, 1'b1, 8'h01, 1'b0});
        @(negedge clk);
        #1 chk("cfg.new_seed", {23'd0, out_valid, out_act_addr_mem, w_sign_mem},
               {23'd0, 1'b1, 8'h02, 1'b1});
        @(negedge clk);

        // Flush with two requests in flight.
        drive_req(4'd0, 10'd7, 10'd0, 8'h07, 16'h0);
        @(negedge clk);
        drive_req(4'd0, 10'd8, 10'd0, 8'h08, 16'h0);
        @(negedge clk);
        drive_req(4'd0, 10'd9, 10'd0, 8'h09, 16'h0);
        flush = 1'b1;
        #1 chk("flush.gate", {30'd0, in_ready, w_mem_cen}, 32'b01);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1 chk("flush.empty", {29'd0, out_valid, w_mem_cen, |out_act_addr_mem}, 32'b010);
        @(negedge clk);
        #1 chk("flush.stays_empty", {30'd0, out_valid, w_mem_cen}, 32'b01);
        run_one("after_flush", 4'd0, 10'd3, 10'd5, 12'h403, 1'b0, 8'h33);

        // Reset with two requests in flight.
        drive_req(4'd0, 10'd7, 10'd0, 8'h07, 16'h0);
        @(negedge clk);
        drive_req(4'd0, 10'd8, 10'd0, 8'h08, 16'h0);
        @(negedge clk);
        in_valid = 1'b0; rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("midreset.empty", {16'd0, 3'd0, out_valid, w_mem_cen, w_mem_addr}, {19'd0, 1'b1, 12'h0});
        @(negedge clk);
        #1 chk("midreset.no_pulse", {30'd0, out_valid, w_mem_cen}, 32'b01);
        run_one("after_reset", 4'd0, 10'h155, 10'd2, 12'h955, 1'b0, 8'h44);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
